fpu_byte_encode: RTL and testbench

Sequential converter from an IEEE-754 single-precision value in [0.0, 1.0] to an 8-bit unsigned integer n = round(x × 255). It is the inverse of the byte-to-float normalizer (n → n/255) in the FPU path. A float produced by that normalizer must return its original byte. Input and output each use a valid/ready handshake, and the block processes one operand at a time.

---
 rtl/fpu_byte_encode_if.sv | 27 ++
 rtl/fpu_byte_encode.sv | 150 +++++++++++++++
 tb/tb_fpu_byte_encode.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_byte_encode_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_byte_encode_if
//  Description : Operand/result valid-ready bundle for fpu_byte_encode.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpu_byte_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  byte_out;
  logic        clamp;
  logic        invalid;

  modport master (
    output in_valid, fp_in, out_ready,
    input  in_ready, out_valid, byte_out, clamp, invalid
  );

  modport slave (
    input  in_valid, fp_in, out_ready,
    output in_ready, out_valid, byte_out, clamp, invalid
  );
endinterface
`default_nettype wire

// File: rtl/fpu_byte_encode.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_byte_encode
//  Description : Multi-cycle float [0,1] -> byte converter, round(x*255).
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_byte_encode (
  input  wire logic         clk,
  input  wire logic         arst,
  fpu_byte_encode_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLASSIFY = 3'd1,
    SHIFT    = 3'd2,
    ROUND    = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_op, w_op_nxt;
  logic [8:0]  r_r, w_r_nxt;
  logic [3:0]  r_k, w_k_nxt;
  logic [7:0]  r_byte, w_byte_nxt;
  logic        r_clamp, w_clamp_nxt;
  logic        r_invalid, w_invalid_nxt;
  logic        r_out_valid, w_out_valid_nxt;

  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_mant;
  logic [23:0] w_m;
  logic [8:0]  w_r_init;
  logic [3:0]  w_k_init;
  logic        w_take_out;

  assign w_sign   = r_op[31];
  assign w_exp    = r_op[30:23];
  assign w_mant   = r_op[22:0];
  assign w_m      = {1'b1, w_mant};
  // R holds floor(2*x*255) once shifted by k, so its LSB is the half-bit for rounding.
  assign w_r_init = 9'(({w_m, 8'h00} - {8'h00, w_m}) >> 23);
  assign w_k_init = 4'(8'd126 - w_exp);
  assign w_take_out = r_out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= IDLE;
      r_op        <= 32'h0;
      r_r         <= 9'h0;
      r_k         <= 4'h0;
      r_byte      <= 8'h00;
      r_clamp     <= 1'b0;
      r_invalid   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_r         <= w_r_nxt;
      r_k         <= w_k_nxt;
      r_byte      <= w_byte_nxt;
      r_clamp     <= w_clamp_nxt;
      r_invalid   <= w_invalid_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_r_nxt         = r_r;
    w_k_nxt         = r_k;
    w_byte_nxt      = r_byte;
    w_clamp_nxt     = r_clamp;
    w_invalid_nxt   = r_invalid;
    w_out_valid_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_op_nxt    = bus.fp_in;
          w_state_nxt = CLASSIFY;
        end
      end

      CLASSIFY: begin
        w_state_nxt   = DONE;
        w_byte_nxt    = 8'h00;
        w_clamp_nxt   = 1'b0;
        w_invalid_nxt = 1'b0;
        if (w_exp == 8'd255 && w_mant != 23'd0) begin
          w_invalid_nxt = 1'b1;
        end else if (w_sign && (w_exp != 8'd0 || w_mant != 23'd0)) begin
          w_clamp_nxt = 1'b1;
        end else if (w_exp == 8'd0) begin
          w_clamp_nxt = 1'b0;
        end else if (w_exp >= 8'd127) begin
          w_byte_nxt  = 8'hFF;
          w_clamp_nxt = 1'b1;
        end else if (w_exp <= 8'd116) begin
          w_clamp_nxt = 1'b0;
        end else begin
          // Result register is only rewritten in ROUND for the normal path.
          w_byte_nxt    = r_byte;
          w_clamp_nxt   = r_clamp;
          w_invalid_nxt = r_invalid;
          w_r_nxt       = w_r_init;
          w_k_nxt       = w_k_init;
          w_state_nxt   = (w_k_init != 4'd0) ? SHIFT : ROUND;
        end
      end

      SHIFT: begin
        w_r_nxt = {1'b0, r_r[8:1]};
        w_k_nxt = r_k - 4'd1;
        if (r_k == 4'd1) begin
          w_state_nxt = ROUND;
        end
      end

      ROUND: begin
        w_byte_nxt    = r_r[8:1] + {7'd0, r_r[0]};
        w_clamp_nxt   = 1'b0;
        w_invalid_nxt = 1'b0;
        w_state_nxt   = DONE;
      end

      DONE: begin
        // out_valid is registered, so it appears one edge after DONE is entered.
        w_out_valid_nxt = ~w_take_out;
        if (w_take_out) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.byte_out  = r_byte;
  assign bus.clamp     = r_clamp;
  assign bus.invalid   = r_invalid;

endmodule
`default_nettype wire

// File: tb/tb_fpu_byte_encode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_byte_encode
//  Description : Directed self-checking bench for fpu_byte_encode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_byte_encode;

  logic clk = 1'b0;
  logic arst;
  int   n_checks = 0;
  int   n_errors = 0;

  fpu_byte_encode_if bus ();

  fpu_byte_encode dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Correctly rounded single-precision encoding of n/255.
  function automatic logic [31:0] norm_float(input int n);
    int     e;
    longint num, q, rem;
    if (n == 0) return 32'h0;
    e = 127;
    while (e > 0 && ((longint'(n) << (127 - e)) < 255)) e--;
    num = longint'(n) << (150 - e);
    q   = num / 255;
    rem = num % 255;
    if (2 * rem > 255) q++;
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e++;
    end
    return {1'b0, 8'(e), q[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] fp, input logic [7:0] eb, input logic ec,
                        input logic ei, input int elat, input string tag);
    int lat;
    @(negedge clk);
    check({tag, "_rdy_pre"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.fp_in    = fp;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, "_rdy_busy"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_byte"}, 32'(bus.byte_out), 32'(eb));
    check({tag, "_clamp"}, 32'(bus.clamp), 32'(ec));
    check({tag, "_invalid"}, 32'(bus.invalid), 32'(ei));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_vld_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_rdy_post"}, 32'(bus.in_ready), 32'd1);
  endtask

  logic [31:0] v_in   [16] = '{32'h3F000000, 32'h3B808081, 32'h3F800000, 32'h7F800000,
                               32'hBF000000, 32'h7FC00000, 32'h00000000, 32'h80000000,
                               32'h80000001, 32'hFF800000, 32'hFFC00000, 32'h00000001,
                               32'h3A000000, 32'h3B000000, 32'h3F400000, 32'h3F7FFFFF};
  logic [7:0]  v_byte [16] = '{8'h80, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hBF, 8'hFF};
  logic        v_clmp [16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        v_inv  [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int          v_lat  [16] = '{3, 10, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 11, 3, 3};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] f;
    int          e, elat;
    logic        seen_vld;

    arst          = 1'b1;
    bus.in_valid  = 1'b0;
    bus.fp_in     = 32'h0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_byte", 32'(bus.byte_out), 32'h00);
    check("rst_clamp", 32'(bus.clamp), 32'd0);
    check("rst_invalid", 32'(bus.invalid), 32'd0);
    @(negedge clk);
    arst = 1'b0;

    for (int i = 0; i < 16; i++)
      run_op(v_in[i], v_byte[i], v_clmp[i], v_inv[i], v_lat[i], $sformatf("vec%0d", i));

    for (int n = 0; n < 256; n++) begin
      f = norm_float(n);
      e = int'(f[30:23]);
      elat = (n == 0 || n == 255) ? 2 : 3 + (126 - e);
      run_op(f, 8'(n), (n == 255) ? 1'b1 : 1'b0, 1'b0, elat, $sformatf("rt%0d", n));
    end

    // Backpressure with a stray operand offered while busy
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.fp_in    = 32'h3F000000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_vld_rise", 32'(bus.out_valid), 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.in_valid = (c == 5);
      bus.fp_in    = 32'h3F800000;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_vld", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp%0d_byte", c), 32'(bus.byte_out), 32'h80);
      check($sformatf("bp%0d_clamp", c), 32'(bus.clamp), 32'd0);
      check($sformatf("bp%0d_rdy", c), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    seen_vld = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen_vld |= bus.out_valid;
    end
    check("bp_no_stray_result", 32'(seen_vld), 32'd0);
    check("bp_rdy_after", 32'(bus.in_ready), 32'd1);

    // Reset during SHIFT
    run_op(32'h3F800000, 8'hFF, 1'b1, 1'b0, 2, "pre_rst");
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.fp_in    = 32'h3B808081;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rdy_busy", 32'(bus.in_ready), 32'd0);
    arst = 1'b1;
    #1;
    check("mid_rst_vld", 32'(bus.out_valid), 32'd0);
    check("mid_rst_byte", 32'(bus.byte_out), 32'h00);
    check("mid_rst_clamp", 32'(bus.clamp), 32'd0);
    check("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    seen_vld = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      seen_vld |= bus.out_valid;
    end
    check("mid_rst_no_pulse", 32'(seen_vld), 32'd0);
    run_op(32'h3F000000, 8'h80, 1'b0, 1'b0, 3, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
